if_stage: RTL and testbench

- Instruction-fetch stage: owns the PC, issues in-order requests to instruction memory, and buffers responses.
- Presents {pc, instr} to the IF/ID boundary, which feeds the decode stage.
- Accepts a redirect (imm_pc / next_imm_pc) from decode.
- Uses an epoch bit to squash wrong-path responses still in flight.

---
 rtl/if_pkg.sv | 30 +++
 rtl/if_stage_fetch_fifo.sv | 81 ++++++++
 rtl/if_stage.sv | 173 +++++++++++++++++
 tb/tb_if_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
//   Shared types and constants for the instruction-fetch stage.
//   - fetch_state_e : fetch sequencer states (BOOT, RUN)
//   - fetch_entry_t : fetch-buffer entry {pc, instr}, default 64/32-bit layout
//   - tag_entry_t   : tag-queue entry {epoch, pc}, default 64-bit layout
//   - INSTR_BYTES   : PC increment per sequential fetch
//   The structs describe the default-width layout; if_stage packs its FIFO
//   words with the same field order but sized from its own parameters.
// -----------------------------------------------------------------------------
package if_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic        epoch;
        logic [63:0] pc;
    } tag_entry_t;

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous FIFO with registered storage, used both as the tag queue and
//   as the fetch buffer inside if_stage.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     push, push_data   write one entry
//     pop               retire the head entry
//     flush             drop all entries (wins over push/pop)
//     head_data         current head entry (registered storage)
//     count             number of valid entries, 0..DEPTH
//   DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        // A push into a full FIFO is only accepted when the head leaves in
        // the same cycle.
        do_push  = push && ((count_q < CW'(DEPTH)) || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
//   Instruction-fetch stage. Owns the PC, issues in-order fetches, tags each
//   request with the current epoch, and buffers responses for decode.
//   Ports:
//     clk, rst                        clock, synchronous active-high reset
//     imem_req_valid/ready/addr       fetch request channel
//     imem_resp_valid/instr           in-order response, no backpressure
//     redirect, redirect_pc           PC redirect from decode
//     id_ready                        decode accepts the presented entry
//     out_valid, out_pc, out_instr    IF/ID entry
//     perf_fetched, perf_squashed     only with IF_PERF_CNT_EN defined
//   Optional feature macro: IF_PERF_CNT_EN (performance counters).
//
//   state | meaning
//   ------+-------------------------------------------
//   BOOT  | first cycle after reset, no requests issued
//   RUN   | fetching
// -----------------------------------------------------------------------------
module if_stage
    import if_pkg::*;
#(
    parameter int                 BUS_WIDTH   = 64,
    parameter int                 INSTR_WIDTH = 32,
    parameter int                 FIFO_DEPTH  = 2,
    parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [BUS_WIDTH-1:0]   imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_instr,
    input  logic                   redirect,
    input  logic [BUS_WIDTH-1:0]   redirect_pc,
    input  logic                   id_ready,
    output logic                   out_valid,
    output logic [BUS_WIDTH-1:0]   out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [63:0]            perf_fetched,
    output logic [63:0]            perf_squashed
`endif
);

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int TAG_W = 1 + BUS_WIDTH;
    localparam int ENT_W = BUS_WIDTH + INSTR_WIDTH;

    fetch_state_e         state_q, state_d;
    logic [BUS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                 epoch_q, epoch_d;

    logic [TAG_W-1:0]     tag_head;
    logic [ENT_W-1:0]     fifo_head;
    logic [CW-1:0]        outstanding;
    logic [CW-1:0]        fifo_count;
    logic [CW:0]          inflight;
    logic                 accept, resp_take, resp_match;
    logic                 fifo_push, fifo_pop;
    logic                 unused_pc_lsbs;

    // The tag queue occupancy is the outstanding-request count.
    assign inflight       = {1'b0, outstanding} + {1'b0, fifo_count};
    assign unused_pc_lsbs = ^redirect_pc[1:0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        epoch_d    = epoch_q;

        if (state_q == BOOT) begin
            state_d = RUN;
        end

        // Reserve a buffer slot for every request in flight so a response
        // always has somewhere to land.
        imem_req_valid = (state_q == RUN) && !redirect
                         && (inflight < (CW+1)'(FIFO_DEPTH));
        accept         = imem_req_valid && imem_req_ready;
        resp_take      = imem_resp_valid && (outstanding != '0);
        resp_match     = resp_take && (tag_head[TAG_W-1] == epoch_q);
        fifo_push      = resp_match && !redirect;
        out_valid      = (fifo_count != '0);
        fifo_pop       = out_valid && id_ready && !redirect;

        if (redirect) begin
            fetch_pc_d = {redirect_pc[BUS_WIDTH-1:2], 2'b00};
            epoch_d    = ~epoch_q;
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + BUS_WIDTH'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            epoch_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            epoch_q    <= epoch_d;
        end
    end

    assign imem_req_addr = fetch_pc_q;

    // Tag queue is never flushed: wrong-path responses still arrive and are
    // discarded by the epoch compare.
    fetch_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data ({epoch_q, fetch_pc_q}),
        .pop       (resp_take),
        .flush     (1'b0),
        .head_data (tag_head),
        .count     (outstanding)
    );

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({tag_head[BUS_WIDTH-1:0], imem_resp_instr}),
        .pop       (fifo_pop),
        .flush     (redirect),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign out_pc    = fifo_head[ENT_W-1:INSTR_WIDTH];
    assign out_instr = fifo_head[INSTR_WIDTH-1:0];

`ifdef IF_PERF_CNT_EN
    logic [63:0] perf_fetched_q, perf_fetched_d;
    logic [63:0] perf_squashed_q, perf_squashed_d;

    // Squashed = responses not written to the buffer plus valid entries
    // thrown away by a redirect flush.
    always_comb begin
        perf_fetched_d  = perf_fetched_q + 64'(fifo_pop);
        perf_squashed_d = perf_squashed_q + 64'(resp_take && !fifo_push)
                          + (redirect ? 64'(fifo_count) : 64'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`endif

    resp_has_tag: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    import if_pkg::*;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_instr;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        id_ready;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
`ifdef IF_PERF_CNT_EN
    logic [63:0] perf_fetched;
    logic [63:0] perf_squashed;
`endif

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_instr (imem_resp_instr),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .id_ready        (id_ready),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_instr       (out_instr)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_squashed   (perf_squashed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    pend_t        pend[$];
    logic [63:0]  acc_q[$];
    fetch_entry_t pops[$];
    int           cnt;
    int           lat;
    int           n_checks;
    int           n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // One clock: sample handshakes at the negedge, then advance the memory
    // model just after the posedge.
    task automatic cyc();
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            acc_q.push_back(imem_req_addr);
            pend.push_back('{imem_req_addr, cnt + lat});
        end
        if (out_valid && id_ready && !redirect)
            pops.push_back('{out_pc, out_instr});
        @(posedge clk);
        #1;
        cnt++;
        if (rst) pend.delete();
        imem_resp_valid = 1'b0;
        imem_resp_instr = '0;
        if (pend.size() > 0 && pend[0].due == cnt) begin
            imem_resp_valid = 1'b1;
            imem_resp_instr = mk(pend[0].addr);
            void'(pend.pop_front());
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;
        imem_req_ready = 1'b1;
        repeat (2) cyc();
        acc_q.delete();
        pops.delete();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        cnt             = 0;
        lat             = 1;
        rst             = 1'b1;
        redirect        = 1'b0;
        redirect_pc     = '0;
        id_ready        = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_instr = '0;

        // Reset state
        repeat (3) cyc();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_pc", out_pc, 64'h0);
        check("rst_out_instr", 64'(out_instr), 64'h0);
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);

        // Sequential fetch, 1-cycle memory
        acc_q.delete();
        pops.delete();
        rst = 1'b0;
        cyc();
        check("t1_req_valid", 64'(imem_req_valid), 64'd1);
        check("t1_req_addr", imem_req_addr, 64'h0);
        check("t1_ov_e1", 64'(out_valid), 64'd0);
        cyc();
        check("t1_ov_e2", 64'(out_valid), 64'd0);
        cyc();
        check("t1_ov_e3", 64'(out_valid), 64'd1);
        check("t1_pc_e3", out_pc, 64'h0);
        check("t1_instr_e3", 64'(out_instr), 64'hC0DE0000);
        repeat (10) cyc();
        check("t1_npops", 64'(pops.size() >= 3), 64'd1);
        if (pops.size() >= 3) begin
            check("t1_pop0_pc", pops[0].pc, 64'h0);
            check("t1_pop1_pc", pops[1].pc, 64'h4);
            check("t1_pop2_pc", pops[2].pc, 64'h8);
            check("t1_pop2_instr", 64'(pops[2].instr), 64'hC0DE0008);
        end
        check("t1_nacc", 64'(acc_q.size() >= 3), 64'd1);
        if (acc_q.size() >= 3) begin
            check("t1_acc1", acc_q[1], 64'h4);
            check("t1_acc2", acc_q[2], 64'h8);
        end

        // Decode stall: at most FIFO_DEPTH fetches accepted, outputs held
        do_reset();
        id_ready = 1'b0;
        repeat (6) cyc();
        check("t2_nacc", 64'(acc_q.size()), 64'd2);
        check("t2_req_valid", 64'(imem_req_valid), 64'd0);
        check("t2_out_valid", 64'(out_valid), 64'd1);
        check("t2_out_pc", out_pc, 64'h0);
        repeat (2) cyc();
        check("t2_out_pc_hold", out_pc, 64'h0);
        check("t2_nacc_hold", 64'(acc_q.size()), 64'd2);
        id_ready = 1'b1;
        repeat (10) cyc();
        check("t2_npops", 64'(pops.size() >= 3), 64'd1);
        if (pops.size() >= 3) begin
            check("t2_pop0_pc", pops[0].pc, 64'h0);
            check("t2_pop1_pc", pops[1].pc, 64'h4);
            check("t2_pop1_instr", 64'(pops[1].instr), 64'hC0DE0004);
            check("t2_pop2_pc", pops[2].pc, 64'h8);
        end

        // Redirect with two responses in flight (3-cycle memory)
        do_reset();
        lat = 3;
        for (int i = 0; i < 20 && acc_q.size() < 2; i++) cyc();
        check("t3_inflight", 64'(acc_q.size()), 64'd2);
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        #1;
        check("t3_req_withdrawn", 64'(imem_req_valid), 64'd0);
        cyc();
        redirect = 1'b0;
        check("t3_ov_after_redir", 64'(out_valid), 64'd0);
        repeat (15) cyc();
        check("t3_npops", 64'(pops.size() >= 1), 64'd1);
        if (pops.size() >= 1) begin
            check("t3_pop0_pc", pops[0].pc, 64'h100);
            check("t3_pop0_instr", 64'(pops[0].instr), 64'hC0DE0100);
        end
        check("t3_nacc", 64'(acc_q.size() >= 4), 64'd1);
        if (acc_q.size() >= 4) begin
            check("t3_acc2", acc_q[2], 64'h100);
            check("t3_acc3", acc_q[3], 64'h104);
        end
`ifdef IF_PERF_CNT_EN
        check("t3_perf_squashed", perf_squashed, 64'd2);
        check("t3_perf_fetched", perf_fetched, 64'(pops.size()));
`endif
        lat = 1;

        // Redirect to misaligned PC while FIFO is full and decode pops
        do_reset();
        id_ready = 1'b0;
        repeat (6) cyc();
        check("t4_full_ov", 64'(out_valid), 64'd1);
        redirect    = 1'b1;
        redirect_pc = 64'h103;
        id_ready    = 1'b1;
        cyc();
        redirect = 1'b0;
        check("t4_flush_ov", 64'(out_valid), 64'd0);
        check("t4_fetch_addr", imem_req_addr, 64'h100);
        cyc();
        check("t4_no_stale", 64'(out_valid), 64'd0);
        repeat (10) cyc();
        check("t4_npops", 64'(pops.size() >= 2), 64'd1);
        if (pops.size() >= 2) begin
            check("t4_pop0_pc", pops[0].pc, 64'h100);
            check("t4_pop0_instr", 64'(pops[0].instr), 64'hC0DE0100);
            check("t4_pop1_pc", pops[1].pc, 64'h104);
        end
`ifdef IF_PERF_CNT_EN
        check("t4_perf_squashed", perf_squashed, 64'd2);
`endif

        // Memory stalls, then reset mid-stall
        do_reset();
        imem_req_ready = 1'b0;
        cyc();
        redirect    = 1'b1;
        redirect_pc = 64'h200;
        cyc();
        redirect = 1'b0;
        repeat (10) cyc();
        check("t5_req_valid", 64'(imem_req_valid), 64'd1);
        check("t5_req_addr", imem_req_addr, 64'h200);
        check("t5_nacc", 64'(acc_q.size()), 64'd0);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b1;
        cyc();
        check("t5_state", 64'(dut.state_q), 64'(BOOT));
        check("t5_fetch_pc", dut.fetch_pc_q, 64'h0);
        check("t5_outstanding", 64'(dut.outstanding), 64'd0);
        check("t5_rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("t5_rst_out_valid", 64'(out_valid), 64'd0);
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        cyc();
        check("t5_restart_valid", 64'(imem_req_valid), 64'd1);
        check("t5_restart_addr", imem_req_addr, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
